result_capture: RTL and testbench

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/rof_pkg.sv | 15 +
 rtl/result_ram.sv | 39 +++
 rtl/result_capture.sv | 107 ++++++++++
 tb/tb_result_capture.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rof_pkg.sv
// Shared constants for the rank-order filter and its result capture buffer.
package rof_pkg;

  localparam int unsigned DefDataBits = 8;
  localparam int unsigned DefAddrBits = 8;
  localparam int unsigned DefDepth    = 255;

  // Capture FSM encodings.
  typedef enum logic [1:0] {
    StSkipping = 2'b00,
    StCapture  = 2'b01,
    StFull     = 2'b10
  } cap_state_e;

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result store: synchronous write, registered read (read-before-write).
module result_ram
  import rof_pkg::*;
#(
  parameter int unsigned DATA_BITS = DefDataBits,
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register samples every cycle, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/result_capture.sv
// Captures filter results after a warm-up skip and lets a button browse the stored buffer.
module result_capture
  import rof_pkg::*;
#(
  parameter int unsigned DATA_BITS = DefDataBits,
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned SKIP      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 read_up,
  input  logic                 read_down,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS-1:0] count,
  output logic                 done
);

  localparam int unsigned SkipW = $clog2(SKIP + 2);
  localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP == 0) ? 0 : SKIP - 1);
  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(DEPTH - 1);
  localparam cap_state_e ResetState = (SKIP == 0) ? StCapture : StSkipping;

  cap_state_e           state_q;
  logic [SkipW-1:0]     skip_q;
  logic [ADDR_BITS-1:0] count_q;
  logic                 done_q;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic                 read_up_q;
  logic                 armed_q;
  logic                 wr_en;
  logic                 step;

  assign wr_en = in_valid && (state_q == StCapture);
  // armed_q keeps a button held through reset release from counting as an edge.
  assign step  = armed_q && read_up && !read_up_q;

  // Capture FSM: skip warm-up results, then fill the buffer until DEPTH entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ResetState;
      skip_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        StSkipping: begin
          skip_q <= skip_q + SkipW'(1);
          if (skip_q == SkipLast) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          count_q <= count_q + ADDR_BITS'(1);
          if (count_q == LastAddr) begin
            state_q <= StFull;
            done_q  <= 1'b1;
          end
        end
        StFull: begin
        end
        default: state_q <= ResetState;
      endcase
    end
  end

  // Browse pointer: one step per rising edge of read_up, wrapping within 0..DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      read_up_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      read_up_q <= read_up;
      armed_q   <= 1'b1;
      if (step) begin
        if (read_down) begin
          rd_addr_q <= (rd_addr_q == '0) ? LastAddr : rd_addr_q - ADDR_BITS'(1);
        end else begin
          rd_addr_q <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + ADDR_BITS'(1);
        end
      end
    end
  end

  result_ram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(count_q),
    .wr_data(in_data),
    .rd_addr(rd_addr_q),
    .rd_data(rd_data)
  );

  assign rd_addr = rd_addr_q;
  assign count   = count_q;
  assign done    = done_q;

endmodule

// File: tb/tb_result_capture.sv
// Directed bench for result_capture with default parameters (SKIP=4, DEPTH=255).
module tb_result_capture;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       read_up;
  logic       read_down;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] count;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       dn;
    logic [7:0] addr;
    logic [7:0] data;
  } browse_vec_t;

  browse_vec_t tbl [8];

  result_capture u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .read_up  (read_up),
    .read_down(read_down),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse(input logic dn);
    @(negedge clk);
    read_down = dn;
    read_up   = 1'b1;
    @(negedge clk);
    read_up = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // addr 0 holds 14 after phase A; walk up through 20 and back down
    for (int i = 0; i < 6; i++) begin
      tbl[i] = '{dn: 1'b0, addr: 8'(i + 1), data: 8'(15 + i)};
    end
    tbl[6] = '{dn: 1'b1, addr: 8'd5, data: 8'd19};
    tbl[7] = '{dn: 1'b1, addr: 8'd4, data: 8'd18};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    read_up = 1'b0;
    read_down = 1'b0;

    // Phase A: 4 discarded, 14..20 stored at 0..6
    do_reset();
    for (int v = 10; v <= 20; v++) feed(8'(v));
    @(negedge clk);
    chk("a_count", 32'(count), 32'd7);
    chk("a_done", 32'(done), 32'd0);
    chk("a_mem0", 32'(rd_data), 32'd14);
    for (int i = 0; i < 8; i++) begin
      pulse(tbl[i].dn);
      chk($sformatf("tbl%0d_addr", i), 32'(rd_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].data));
    end

    // Phase B: abort mid-run, re-run overwrites from 0; same-address write/read
    do_reset();
    for (int v = 0; v < 4; v++) feed(8'hF0);
    for (int v = 0; v < 5; v++) feed(8'(8'h50 + v));
    @(negedge clk);
    chk("b_count", 32'(count), 32'd5);
    chk("b_mem0_new", 32'(rd_data), 32'h50);
    for (int i = 0; i < 5; i++) pulse(1'b0);
    chk("b_addr5", 32'(rd_addr), 32'd5);
    chk("b_mem5_old", 32'(rd_data), 32'd19);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h7A;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b_rw_old", 32'(rd_data), 32'd19);
    @(negedge clk);
    chk("b_rw_new", 32'(rd_data), 32'h7A);
    chk("b_count6", 32'(count), 32'd6);
    pulse(1'b0);
    chk("b_mem6_stale", 32'(rd_data), 32'd20);

    // Phase C: fill to DEPTH, then extra results are ignored
    for (int i = 6; i < 254; i++) feed(8'(i) ^ 8'hA5);
    @(negedge clk);
    chk("c_count254", 32'(count), 32'd254);
    chk("c_done_pre", 32'(done), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'd254 ^ 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("c_done_post", 32'(done), 32'd1);
    chk("c_count255", 32'(count), 32'd255);
    for (int i = 0; i < 45; i++) feed(8'hEE);
    @(negedge clk);
    chk("c_count_hold", 32'(count), 32'd255);
    chk("c_done_hold", 32'(done), 32'd1);
    chk("c_mem6_full", 32'(rd_data), 32'(8'd6 ^ 8'hA5));

    // Phase D: read_up held through reset release must not step; then wrap both ways
    @(negedge clk);
    read_up = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    chk("d_no_step", 32'(rd_addr), 32'd0);
    read_up = 1'b0;
    @(negedge clk);
    pulse(1'b1);
    chk("d_wrap_dn", 32'(rd_addr), 32'd254);
    chk("d_mem254", 32'(rd_data), 32'(8'd254 ^ 8'hA5));
    pulse(1'b0);
    chk("d_wrap_up", 32'(rd_addr), 32'd0);
    chk("d_mem0", 32'(rd_data), 32'h50);

    // Phase E: long hold = one step; simultaneous write and edge both land
    for (int v = 0; v < 4; v++) feed(8'h01);
    @(negedge clk);
    read_down = 1'b0;
    read_up   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (1000) @(negedge clk);
    chk("e_one_step", 32'(rd_addr), 32'd1);
    chk("e_count", 32'(count), 32'd1);
    read_up = 1'b0;
    @(negedge clk);
    pulse(1'b1);
    chk("e_addr0", 32'(rd_addr), 32'd0);
    chk("e_mem0", 32'(rd_data), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
